// File: rtl/proj_scheduler.sv
// Shares one perspective-projection unit between two triangle sources:
// round-robin grant, near-plane cull, start/finish sequencing and a valid/ready result port.
module proj_scheduler #(
  parameter int W     = 32,
  parameter int ZNEAR = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [9*W-1:0] req0_tri,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [9*W-1:0] req1_tri,
  output logic           pu_start,
  output logic [9*W-1:0] pu_tri,
  input  logic           pu_finish,
  input  logic [6*W-1:0] pu_res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [6*W-1:0] out_tri,
  output logic           out_src,
  output logic           busy,
  output logic [15:0]    cull_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, OUT} state_e;

  localparam logic signed [W-1:0] ZN = W'(ZNEAR);

  state_e         state_q;
  logic           last_q;
  logic [9*W-1:0] tri_q;
  logic           src_q;
  logic [6*W-1:0] res_q;
  logic [15:0]    cull_q;
  logic [15:0]    cull_d;
  logic           start_q;
  logic           valid_q;
  logic           busy_q;

  logic           gnt_any;
  logic           gnt_src;
  logic [9*W-1:0] gnt_tri;
  logic signed [W-1:0] gz1;
  logic signed [W-1:0] gz2;
  logic signed [W-1:0] gz3;
  logic           gnt_cull;

  function automatic logic near_cull(input logic signed [W-1:0] z1,
                                     input logic signed [W-1:0] z2,
                                     input logic signed [W-1:0] z3);
    return (z1 <= ZN) || (z2 <= ZN) || (z3 <= ZN);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Grant is combinational and only offered in IDLE; a tie goes to the source not served last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_src = ~last_q;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_src = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_src = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any & ~gnt_src;
  assign req1_ready = gnt_any &  gnt_src;
  assign gnt_tri    = gnt_src ? req1_tri : req0_tri;
  assign gz1        = gnt_tri[6*W +: W];
  assign gz2        = gnt_tri[3*W +: W];
  assign gz3        = gnt_tri[0   +: W];
  assign gnt_cull   = near_cull(gz1, gz2, gz3);
  assign cull_d     = sat_inc(cull_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tri_q   <= '0;
      src_q   <= 1'b0;
      res_q   <= '0;
      cull_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            last_q <= gnt_src;
            if (gnt_cull) begin
              cull_q <= cull_d;
            end else begin
              tri_q   <= gnt_tri;
              src_q   <= gnt_src;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= GUARD;
        // The unit still shows the previous finish here; it is cleared only after start.
        GUARD: state_q <= WAIT;
        WAIT: begin
          if (pu_finish) begin
            res_q   <= pu_res;
            valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pu_start   = start_q;
  assign pu_tri     = tri_q;
  assign out_valid  = valid_q;
  assign out_tri    = res_q;
  assign out_src    = src_q;
  assign busy       = busy_q;
  assign cull_count = cull_q;

endmodule

// File: doc/proj_scheduler.md
# proj_scheduler

Controller that shares one perspective-projection unit between two triangle sources. It arbitrates round-robin between the sources, culls triangles that cross the near plane, and sequences the unit's `start`/`finish` handshake. It captures the six projected coordinates and presents them to the downstream rasterizer over a valid/ready interface. It sits between the geometry front-ends and the line/triangle rasterizer.

## Interface
- `W`, 32: coordinate width; all coordinates are signed two's complement.
- `ZNEAR`, 1: near-plane threshold. A triangle is culled if any of its z values is ≤ ZNEAR (signed compare).
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0_valid`  in  1: source 0 has a triangle.
- `req0_ready`  out  1: source 0 triangle accepted this cycle.
- `req0_tri`  in  9W: packed {x1,y1,z1,x2,y2,z2,x3,y3,z3}, x1 in the MSBs.
- `req1_valid`, `req1_ready`, `req1_tri`: same as source 0, for source 1.
- `pu_start`  out  1: start pulse to the projection unit.
- `pu_tri`  out  9W: operand bus to the unit, packed as `req*_tri`.
- `pu_finish`  in  1: unit done, level signal.
- `pu_res`  in  6W: {ox1,oy1,ox2,oy2,ox3,oy3}, ox1 in the MSBs.
- `out_valid`  out  1: projected triangle available.
- `out_ready`  in  1: rasterizer accepts.
- `out_tri`  out  6W: captured `pu_res`.
- `out_src`  out  1: source index of `out_tri`.
- `busy`  out  1: high in any state except IDLE.
- `cull_count`  out  16: count of culled triangles; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, ISSUE, GUARD, WAIT, OUT.
- **IDLE, grant.**
  - Grant goes to the single valid source.
  - If both sources are valid, grant goes to the source not granted last. The pointer resets to "last = 1", so source 0 wins the first tie.
  - `reqN_ready` = 1 combinationally, only for the granted source, only in IDLE.
  - A handshake (`valid & ready`) consumes the triangle and flips the pointer to N. This applies to culled triangles too.
- **IDLE, accepted triangle.**
  - Culled (any z ≤ ZNEAR): increment `cull_count` (saturating) and remain in IDLE. The next grant can occur in the very next cycle.
  - Otherwise: latch the triangle into `pu_tri`, latch the source index, and go to ISSUE.
- **ISSUE:** `pu_start` = 1 for exactly this cycle. Go to GUARD.
- **GUARD:** `pu_finish` is ignored, because the unit clears its stale finish flag only after start. Go to WAIT.
- **WAIT:** hold until `pu_finish` = 1. In that cycle, capture `pu_res` into `out_tri` and go to OUT.
- **OUT:**
  - `out_valid` = 1. `out_tri` and `out_src` are stable until the handshake.
  - On `out_valid & out_ready`, go to IDLE.
- `pu_tri` is held constant from ISSUE until the next accept.
- No arithmetic beyond the z compares and the saturating counter. The divide-by-zero hazard in the unit is impossible because z ≤ ZNEAR (≥ 0) is culled.

## Timing
- **Reset values:** all outputs 0 (`pu_start`, `pu_tri`, `out_valid`, `out_tri`, `out_src`, `busy`, `cull_count`, both `ready` signals); FSM in IDLE; pointer "last = 1".
- **Reset mid-operation:** return immediately to IDLE. The in-flight triangle is dropped; the unit's subsequent `finish` is ignored.
- **Cycle sequence:** accept at cycle T → `pu_start` at T+1 → GUARD at T+2 → WAIT from T+3.
  - If `pu_finish` is first seen high at cycle F ≥ T+3, then `out_valid` = 1 from F+1.
  - Output handshake at cycle H → IDLE at H+1; the earliest next accept is H+1.
- **Throughput:** one triangle in flight, no buffering. `reqN_ready` stays 0 while `busy`.
- **Back-pressure:** `out_ready` = 0 holds OUT indefinitely with outputs stable.
- **Simultaneous events:** both sources valid in IDLE → exactly one `ready` asserted, per the pointer.
- **`cull_count` at 16'hFFFF:** stays at FFFF; culls still consume the triangle.
- **`pu_finish` high in ISSUE or GUARD:** ignored.

## Test plan
1. **Single triangle, basic path.** Reset, then source 0 sends (35,40,800),(10,20,650),(30,60,1000) with the D=600 unit attached and `out_ready` = 1.
   - Required: `pu_start` one cycle after accept.
   - Required: `out_tri` = {26,30,9,18,18,36}, `out_src` = 0.
   - Required: `busy` returns to 0.
2. **Round-robin.** Both sources continuously valid with distinct triangles.
   - Required: grant order 0,1,0,1.
   - Required: `out_src` alternates, and each `out_tri` matches its source's projection.
3. **Near-plane cull.** Source 1 sends a triangle with z2 = 1, then a valid triangle.
   - Required: the first is consumed with no `pu_start` and `cull_count` = 1.
   - Required: the second is projected normally.
4. **Back-pressure.** `out_ready` held 0 for 10 cycles after `out_valid` rises.
   - Required: `out_tri`/`out_valid` stable and both `ready` signals 0.
   - Required: release → IDLE on the next cycle.
5. **Reset mid-WAIT.** Assert `rst` during WAIT.
   - Required: all outputs 0 immediately.
   - Required: the later `pu_finish` produces no `out_valid`.
   - Required: the next triangle completes correctly.
6. **Counter saturation.** Force 65,537 culls.
   - Required: `cull_count` = 16'hFFFF, with no wrap.
